// File: rtl/axi4_burst_master.sv
// AXI4 burst initiator: turns one command into a single INCR burst on an
// AXI4 master port. Write beats come from a valid/ready stream and read beats
// leave through a valid/ready stream. Only one transaction is in flight.
// Commands that are misaligned or would cross a 4 KB page are rejected with
// SLVERR status and never reach the bus.
module axi4_burst_master #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    // command interface
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [7:0]           cmd_len,
    output logic                 done,
    output logic [1:0]           done_resp,
    // write data stream
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    // read data stream
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 rd_last,
    output logic                 busy,
    // AXI4 write address
    output logic [ADDR_W-1:0]    awaddr,
    output logic [7:0]           awlen,
    output logic [2:0]           awsize,
    output logic [1:0]           awburst,
    output logic [2:0]           awprot,
    output logic                 awvalid,
    input  logic                 awready,
    // AXI4 write data
    output logic [WIDTH-1:0]     wdata,
    output logic [WIDTH/8-1:0]   wstrb,
    output logic                 wlast,
    output logic                 wvalid,
    input  logic                 wready,
    // AXI4 write response
    input  logic [1:0]           bresp,
    input  logic                 bvalid,
    output logic                 bready,
    // AXI4 read address
    output logic [ADDR_W-1:0]    araddr,
    output logic [7:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    output logic [2:0]           arprot,
    output logic                 arvalid,
    input  logic                 arready,
    // AXI4 read data
    input  logic [WIDTH-1:0]     rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready
);

    localparam int         SIZE_LOG2 = (WIDTH == 64) ? 3 : 2;
    localparam logic [2:0] AXSIZE    = (WIDTH == 64) ? 3'd3 : 3'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t              state_r;
    state_t              state_n;

    logic [ADDR_W-1:0]   addr_r;
    logic [7:0]          len_r;
    logic [8:0]          cnt_r;       // 9 bits so a 256-beat burst never wraps
    logic [1:0]          rresp_r;     // first non-OKAY read response
    logic                perr_r;      // rlast disagreed with our beat counter
    logic [1:0]          done_resp_r;
    logic                cmd_ready_r;

    logic                misaligned_s;
    logic [13:0]         span_end_s;
    logic                cmd_illegal_s;
    logic                cmd_fire_s;
    logic                last_s;
    logic                w_fire_s;
    logic                b_fire_s;
    logic                r_fire_s;
    logic [1:0]          rresp_sticky_s;
    logic                perr_next_s;

    // Static AXI fields: full-width INCR bursts, unprivileged secure data.
    assign awsize    = AXSIZE;
    assign arsize    = AXSIZE;
    assign awburst   = 2'b01;
    assign arburst   = 2'b01;
    assign awprot    = 3'b000;
    assign arprot    = 3'b000;
    assign wstrb     = {(WIDTH/8){1'b1}};
    assign awaddr    = addr_r;
    assign araddr    = addr_r;
    assign awlen     = len_r;
    assign arlen     = len_r;
    assign wdata     = wr_data;
    assign rd_data   = rdata;
    assign cmd_ready = cmd_ready_r;
    assign done_resp = done_resp_r;

    // Command legality: bus-width alignment and no 4 KB page crossing.
    always_comb begin
        misaligned_s  = |cmd_addr[SIZE_LOG2-1:0];
        span_end_s    = {2'b00, cmd_addr[11:0]}
                      + (({6'd0, cmd_len} + 14'd1) << SIZE_LOG2);
        cmd_illegal_s = misaligned_s || (span_end_s > 14'd4096);
    end

    // Read status bookkeeping for the beat currently on the R channel.
    always_comb begin
        last_s         = (cnt_r == {1'b0, len_r});
        rresp_sticky_s = (rresp_r == 2'b00) ? rresp : rresp_r;
        perr_next_s    = perr_r | (rlast != last_s);
    end

    // State register; async reset drops every handshake output at once.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state decode and channel outputs; valids depend only on state.
    always_comb begin
        state_n    = state_r;
        cmd_fire_s = 1'b0;
        w_fire_s   = 1'b0;
        b_fire_s   = 1'b0;
        r_fire_s   = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        wr_ready   = 1'b0;
        bready     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        rd_valid   = 1'b0;
        rd_last    = 1'b0;
        done       = 1'b0;
        busy       = (state_r != S_IDLE);
        case (state_r)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    cmd_fire_s = 1'b1;
                    if (cmd_illegal_s) begin
                        state_n = S_DONE;
                    end else if (cmd_write) begin
                        state_n = S_AW;
                    end else begin
                        state_n = S_AR;
                    end
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_n = S_W;
                end else begin
                    state_n = S_AW;
                end
            end
            S_W: begin
                wvalid   = wr_valid;
                wr_ready = wready;
                wlast    = last_s;
                w_fire_s = wr_valid && wready;
                if (w_fire_s && last_s) begin
                    state_n = S_B;
                end else begin
                    state_n = S_W;
                end
            end
            S_B: begin
                bready   = 1'b1;
                b_fire_s = bvalid;
                if (bvalid) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_B;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_n = S_R;
                end else begin
                    state_n = S_AR;
                end
            end
            S_R: begin
                rd_valid = rvalid;
                rready   = rd_ready;
                rd_last  = last_s;
                r_fire_s = rvalid && rd_ready;
                if (r_fire_s && last_s) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_R;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Command latch, beat counter and completion status.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_r      <= {ADDR_W{1'b0}};
            len_r       <= 8'd0;
            cnt_r       <= 9'd0;
            rresp_r     <= 2'b00;
            perr_r      <= 1'b0;
            done_resp_r <= 2'b00;
            cmd_ready_r <= 1'b0;
        end else begin
            cmd_ready_r <= (state_n == S_IDLE);
            if (cmd_fire_s) begin
                addr_r      <= cmd_addr;
                len_r       <= cmd_len;
                cnt_r       <= 9'd0;
                rresp_r     <= 2'b00;
                perr_r      <= 1'b0;
                done_resp_r <= cmd_illegal_s ? 2'b10 : 2'b00;
            end else if (w_fire_s) begin
                cnt_r <= cnt_r + 9'd1;
            end else if (b_fire_s) begin
                done_resp_r <= bresp;
            end else if (r_fire_s) begin
                cnt_r   <= cnt_r + 9'd1;
                rresp_r <= rresp_sticky_s;
                perr_r  <= perr_next_s;
                if (last_s) begin
                    done_resp_r <= perr_next_s ? 2'b10 : rresp_sticky_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master with a small AXI4 memory slave,
// a write-stream source and a read-stream sink, all with optional backpressure.
module tb_axi4_burst_master;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [7:0]  cmd_len = 8'd0;
    wire         cmd_ready, done, busy;
    wire  [1:0]  done_resp;
    logic [31:0] wr_data = 32'd0;
    logic        wr_valid = 1'b0;
    wire         wr_ready;
    wire  [31:0] rd_data;
    wire         rd_valid, rd_last;
    logic        rd_ready = 1'b0;
    wire  [31:0] awaddr, araddr, wdata;
    wire  [7:0]  awlen, arlen;
    wire  [2:0]  awsize, awprot, arsize, arprot;
    wire  [1:0]  awburst, arburst;
    wire  [3:0]  wstrb;
    wire         awvalid, wlast, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0;
    logic        rvalid = 1'b0, rlast = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = 32'd0;

    axi4_burst_master #(.WIDTH(32), .ADDR_W(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .done(done), .done_resp(done_resp),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .busy(busy),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    // knobs set by the directed sequence
    bit bp = 1'b0;       // random backpressure everywhere
    bit err0 = 1'b0;     // slave returns DECERR on read beat 0
    bit early = 1'b0;    // slave asserts rlast on read beat 1
    bit stall_en = 1'b0; // slave withholds wready once stall_at beats logged
    int stall_at = 0;

    int n_tests = 0;
    int n_fail = 0;

    // ---------------- write stream source ----------------
    logic [31:0] wbuf [0:1023];
    int w_i = 0, w_end = 0, w_i_n;
    wire w_hs = wr_valid && wr_ready;
    assign w_i_n = w_hs ? w_i + 1 : w_i;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_valid <= 1'b0;
        end else begin
            if (w_hs) w_i <= w_i + 1;
            if (!wr_valid || w_hs) begin
                wr_valid <= (w_i_n < w_end) && (!bp || ($urandom_range(0, 1) == 1));
                wr_data  <= wbuf[w_i_n % 1024];
            end
        end
    end

    // ---------------- read stream sink ----------------
    logic [31:0] rlog [0:1023];
    logic        rllog [0:1023];
    int r_k = 0;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ready <= 1'b0;
        end else begin
            rd_ready <= !bp || ($urandom_range(0, 1) == 1);
            if (rd_valid && rd_ready) begin
                rlog[r_k % 1024]  <= rd_data;
                rllog[r_k % 1024] <= rd_last;
                r_k <= r_k + 1;
            end
        end
    end

    // ---------------- AXI slave: write side ----------------
    logic [31:0] mem [0:1023];
    logic [31:0] wlog [0:1023];
    logic        wllog [0:1023];
    int wk = 0, wk_n, awv_cycles = 0, aw_hs_cnt = 0;
    logic [9:0]  wa = 10'd0;
    logic        aw_hold = 1'b0, aw_unstable = 1'b0;
    logic [31:0] aw_hold_addr = 32'd0;
    logic [7:0]  aw_hold_len = 8'd0;
    wire w_beat = wvalid && wready;
    assign wk_n = w_beat ? wk + 1 : wk;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            aw_hold <= 1'b0;
        end else begin
            awready <= !bp || ($urandom_range(0, 1) == 1);
            wready  <= !(stall_en && (wk_n >= stall_at)) && (!bp || ($urandom_range(0, 1) == 1));
            if (awvalid) awv_cycles <= awv_cycles + 1;
            if (awvalid && awready) begin
                wa <= awaddr[11:2];
                aw_hs_cnt <= aw_hs_cnt + 1;
            end
            if (aw_hold && (!awvalid || awaddr != aw_hold_addr || awlen != aw_hold_len))
                aw_unstable <= 1'b1;
            aw_hold      <= awvalid && !awready;
            aw_hold_addr <= awaddr;
            aw_hold_len  <= awlen;
            if (w_beat) begin
                mem[wa] <= wdata;
                wa <= wa + 10'd1;
                wlog[wk % 1024]  <= wdata;
                wllog[wk % 1024] <= wlast;
                wk <= wk + 1;
                if (wlast) begin
                    bvalid <= 1'b1;
                    bresp  <= 2'b00;
                end
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // ---------------- AXI slave: read side ----------------
    int rleft = 0, rbeat = 0, rleft_n, rbeat_n, arv_cycles = 0, ar_hs_cnt = 0;
    logic [9:0]  ra = 10'd0, ra_n;
    logic        ar_hold = 1'b0, ar_unstable = 1'b0;
    logic [31:0] ar_hold_addr = 32'd0;
    logic [7:0]  ar_hold_len = 8'd0;
    wire r_hs  = rvalid && rready;
    wire ar_hs = arvalid && arready;
    assign rleft_n = ar_hs ? int'(arlen) + 1 : (r_hs ? rleft - 1 : rleft);
    assign rbeat_n = ar_hs ? 0 : (r_hs ? rbeat + 1 : rbeat);
    assign ra_n    = ar_hs ? araddr[11:2] : (r_hs ? ra + 10'd1 : ra);

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= 2'b00;
            rleft   <= 0;
            rbeat   <= 0;
            ar_hold <= 1'b0;
        end else begin
            arready <= !bp || ($urandom_range(0, 1) == 1);
            if (arvalid) arv_cycles <= arv_cycles + 1;
            if (ar_hs) ar_hs_cnt <= ar_hs_cnt + 1;
            if (ar_hold && (!arvalid || araddr != ar_hold_addr || arlen != ar_hold_len))
                ar_unstable <= 1'b1;
            ar_hold      <= arvalid && !arready;
            ar_hold_addr <= araddr;
            ar_hold_len  <= arlen;
            rleft <= rleft_n;
            rbeat <= rbeat_n;
            ra    <= ra_n;
            if (!rvalid || r_hs) begin
                rvalid <= (rleft_n > 0) && (!bp || ($urandom_range(0, 1) == 1));
                rdata  <= mem[ra_n];
                rresp  <= (err0 && rbeat_n == 0) ? 2'b11 : 2'b00;
                rlast  <= early ? (rbeat_n == 1) : (rleft_n == 1);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [7:0] l);
        int cyc = 0;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && cyc < 50) begin
            @(negedge aclk);
            cyc++;
        end
        check("cmd_ready_seen", cmd_ready, 1'b1);
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int cyc, output logic [1:0] resp);
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge aclk);
            cyc++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        resp = done_resp;
        @(negedge aclk);
        check({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    task automatic load_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) wbuf[(w_i + i) % 1024] = base + i;
        w_end = w_i + n;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc, k0, a0;
        logic [1:0] resp;

        // reset state
        repeat (2) @(negedge aclk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_done_resp", done_resp, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_wvalid_bready", {wvalid, bready, wr_ready, rd_valid, rready}, 5'b0);
        check("rst_awaddr", awaddr, 32'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        check("idle_cmd_ready", cmd_ready, 1'b1);
        check("static_aw", {awsize, awburst, awprot}, {3'd2, 2'b01, 3'b000});
        check("static_ar", {arsize, arburst, arprot}, {3'd2, 2'b01, 3'b000});
        check("static_wstrb", wstrb, 4'hF);

        // write 0x100 len 3, data A0..A3
        k0 = wk;
        load_words(32'hA0, 4);
        issue(1'b1, 32'h100, 8'd3);
        wait_done("wr1", 100, cyc, resp);
        check("wr1_resp", resp, 2'b00);
        check("wr1_beats", wk - k0, 4);
        for (int i = 0; i < 4; i++) begin
            check("wr1_wdata", wlog[(k0 + i) % 1024], 32'hA0 + i);
            check("wr1_wlast", wllog[(k0 + i) % 1024], (i == 3) ? 1'b1 : 1'b0);
        end
        check("wr1_cmd_ready_after", cmd_ready, 1'b1);

        // read back
        k0 = r_k;
        issue(1'b0, 32'h100, 8'd3);
        wait_done("rd1", 100, cyc, resp);
        check("rd1_resp", resp, 2'b00);
        check("rd1_beats", r_k - k0, 4);
        for (int i = 0; i < 4; i++) begin
            check("rd1_data", rlog[(k0 + i) % 1024], 32'hA0 + i);
            check("rd1_last", rllog[(k0 + i) % 1024], (i == 3) ? 1'b1 : 1'b0);
        end

        // 16-beat burst at 0x200 under random backpressure
        bp = 1'b1;
        k0 = wk;
        load_words(32'h1000_0000, 16);
        issue(1'b1, 32'h200, 8'd15);
        wait_done("wr16", 800, cyc, resp);
        check("wr16_resp", resp, 2'b00);
        check("wr16_beats", wk - k0, 16);
        for (int i = 0; i < 16; i++) begin
            check("wr16_wdata", wlog[(k0 + i) % 1024], 32'h1000_0000 + i);
            check("wr16_wlast", wllog[(k0 + i) % 1024], (i == 15) ? 1'b1 : 1'b0);
        end
        k0 = r_k;
        issue(1'b0, 32'h200, 8'd15);
        wait_done("rd16", 800, cyc, resp);
        check("rd16_resp", resp, 2'b00);
        check("rd16_beats", r_k - k0, 16);
        for (int i = 0; i < 16; i++)
            check("rd16_data", rlog[(k0 + i) % 1024], 32'h1000_0000 + i);
        check("aw_stable", aw_unstable, 1'b0);
        check("ar_stable", ar_unstable, 1'b0);
        bp = 1'b0;
        repeat (4) @(negedge aclk);

        // 4 KB crossing: rejected, no AW traffic, done on first cycle after accept
        a0 = awv_cycles;
        issue(1'b1, 32'hFF8, 8'd3);
        wait_done("x4k", 20, cyc, resp);
        check("x4k_latency", cyc, 0);
        check("x4k_resp", resp, 2'b10);
        check("x4k_no_awvalid", awv_cycles - a0, 0);

        // unaligned address: rejected the same way
        a0 = awv_cycles;
        issue(1'b1, 32'h102, 8'd0);
        wait_done("unal", 20, cyc, resp);
        check("unal_latency", cyc, 0);
        check("unal_resp", resp, 2'b10);
        check("unal_no_awvalid", awv_cycles - a0, 0);

        // exactly reaching the page end is legal
        a0 = ar_hs_cnt;
        k0 = r_k;
        issue(1'b0, 32'hFF0, 8'd3);
        wait_done("edge4k", 100, cyc, resp);
        check("edge4k_resp", resp, 2'b00);
        check("edge4k_ar", ar_hs_cnt - a0, 1);
        check("edge4k_beats", r_k - k0, 4);

        // DECERR on beat 0 is kept sticky, all beats still delivered
        err0 = 1'b1;
        k0 = r_k;
        issue(1'b0, 32'h100, 8'd3);
        wait_done("rerr", 100, cyc, resp);
        err0 = 1'b0;
        check("rerr_resp", resp, 2'b11);
        check("rerr_beats", r_k - k0, 4);
        check("rerr_data3", rlog[(k0 + 3) % 1024], 32'hA3);

        // early rlast: own counter still terminates, protocol error reported
        early = 1'b1;
        k0 = r_k;
        issue(1'b0, 32'h100, 8'd3);
        wait_done("rlast", 100, cyc, resp);
        early = 1'b0;
        check("rlast_resp", resp, 2'b10);
        check("rlast_beats", r_k - k0, 4);
        check("rlast_own_last", {rllog[(k0 + 1) % 1024], rllog[(k0 + 3) % 1024]}, 2'b01);

        // reset in the middle of a write, with beat 2 pending
        stall_at = wk + 2;
        stall_en = 1'b1;
        load_words(32'hC0, 4);
        issue(1'b1, 32'h300, 8'd3);
        cyc = 0;
        while (!(wk == stall_at && wvalid === 1'b1) && cyc < 100) begin
            @(negedge aclk);
            cyc++;
        end
        check("mid_wvalid_before_rst", wvalid, 1'b1);
        check("mid_bus_before_rst", busy, 1'b1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_awvalid", awvalid, 1'b0);
        check("mid_rst_wvalid", wvalid, 1'b0);
        check("mid_rst_bready", bready, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        w_end = w_i;
        stall_en = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            check("mid_rst_hold_done", done, 1'b0);
        end
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        check("post_rst_cmd_ready", cmd_ready, 1'b1);
        k0 = r_k;
        issue(1'b0, 32'h100, 8'd0);
        wait_done("post_rst", 100, cyc, resp);
        check("post_rst_resp", resp, 2'b00);
        check("post_rst_beats", r_k - k0, 1);
        check("post_rst_data", rlog[k0 % 1024], 32'hA0);
        check("post_rst_last", rllog[k0 % 1024], 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
